// File: rtl/iv_job_sequencer_pkg.sv
// Shared definitions for the integrity-verifier job sequencer: lane state
// encoding and the width derivations used by the top level and its bench.
package iv_job_sequencer_pkg;

  // One encoding for both lanes; exposed on debug ports of the top level.
  typedef enum logic [2:0] {
    LANE_IDLE   = 3'd0,
    LANE_START  = 3'd1,
    LANE_GUARD0 = 3'd2,
    LANE_GUARD1 = 3'd3,
    LANE_WAIT   = 3'd4,
    LANE_ACK    = 3'd5
  } lane_state_t;

  // Width of a tree-level field for a tree of depth oram_l.
  function automatic int oram_log_l(input int oram_l);
    return $clog2(oram_l + 1);
  endfunction

  // Width of a bucket ID for a tree of depth oram_l.
  function automatic int bid_width(input int oram_l);
    return oram_l + 1;
  endfunction

  // Packed ROI descriptor: {level, version, bucket id, from_cc}.
  function automatic int roi_desc_width(input int oram_l, input int aes_entropy);
    return oram_log_l(oram_l) + aes_entropy + bid_width(oram_l) + 1;
  endfunction

endpackage

// File: rtl/iv_lane_ctrl.sv
// One job lane: issues a start pulse, ignores the stale Done level for two
// guard cycles, waits for Done, then acks. A per-lane watchdog counts cycles
// since the start pulse and raises a one-cycle timeout event if WAIT drags on;
// the lane then parks in WAIT for good (only reset frees it).
//
// Handshake: start is a request qualified by the caller; it is taken only in
// IDLE. done is a level from the verifier, looked at only in WAIT.
module iv_lane_ctrl
  import iv_job_sequencer_pkg::*;
#(
  parameter int TimeoutCycles = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        done,
  output logic        start_pulse,
  output logic        ack,
  output logic        timeout,
  output logic        idle,
  output lane_state_t state
);

  localparam int CW = $clog2(TimeoutCycles) + 1;

  logic [CW-1:0] wd_cnt;
  logic          expired;

  // Done seen in WAIT has priority over the watchdog in the same cycle.
  assign timeout = (state == LANE_WAIT) && !done && !expired &&
                   (wd_cnt == CW'(TimeoutCycles - 1));
  assign idle    = (state == LANE_IDLE);

  // Lane FSM with registered start/ack pulses and the watchdog counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= LANE_IDLE;
      wd_cnt      <= '0;
      expired     <= 1'b0;
      start_pulse <= 1'b0;
      ack         <= 1'b0;
    end else begin
      start_pulse <= 1'b0;
      ack         <= 1'b0;
      case (state)
        LANE_IDLE: begin
          if (start) begin
            state       <= LANE_START;
            start_pulse <= 1'b1;
            wd_cnt      <= '0;
          end
        end
        LANE_START: begin
          state  <= LANE_GUARD0;
          wd_cnt <= wd_cnt + 1'b1;
        end
        LANE_GUARD0: begin
          state  <= LANE_GUARD1;
          wd_cnt <= wd_cnt + 1'b1;
        end
        LANE_GUARD1: begin
          state  <= LANE_WAIT;
          wd_cnt <= wd_cnt + 1'b1;
        end
        LANE_WAIT: begin
          if (expired) begin
            state <= LANE_WAIT;
          end else if (done) begin
            state <= LANE_ACK;
            ack   <= 1'b1;
          end else if (timeout) begin
            expired <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        LANE_ACK: state <= LANE_IDLE;
        default:  state <= LANE_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/iv_job_sequencer.sv
// Sequences path and ROI jobs from the coherence controller into the
// integrity verifier. Holds the ROI descriptor queue, arbitrates the two lanes
// (path wins a same-cycle start), holds the active ROI descriptor stable for
// the whole job and keeps the sticky watchdog error.
//
// Handshakes: PathReq/PathReqReady and ROIReq/ROIReqReady transfer on a cycle
// where both are 1; the Ready outputs never depend on the matching Req.
module iv_job_sequencer
  import iv_job_sequencer_pkg::*;
#(
  parameter int ORAML         = 31,
  parameter int AESEntropy    = 64,
  parameter int ROIQDepth     = 2,
  parameter int TimeoutCycles = 4096
) (
  input  logic                        Clock,
  input  logic                        Reset,
  input  logic                        PathReq,
  output logic                        PathReqReady,
  output logic                        PathAck,
  input  logic                        ROIReq,
  output logic                        ROIReqReady,
  input  logic [$clog2(ORAML+1)-1:0]  ROILevelIn,
  input  logic [AESEntropy-1:0]       ROIBVIn,
  input  logic [ORAML:0]              ROIBIDIn,
  input  logic                        ROIFromCCIn,
  output logic                        ROIAck,
  output logic                        IVPathReady,
  output logic                        IVBOIReady,
  output logic [$clog2(ORAML+1)-1:0]  IVROILevel,
  output logic [AESEntropy-1:0]       IVROIBV,
  output logic [ORAML:0]              IVROIBID,
  output logic                        IVBOIFromCC,
  input  logic                        IVPathDone,
  input  logic                        IVBOIDone,
  output logic                        Busy,
  output logic                        Error,
  output lane_state_t                 path_lane_state,
  output lane_state_t                 roi_lane_state
);

  localparam int DescWidth = roi_desc_width(ORAML, AESEntropy);
  localparam int PtrW      = $clog2(ROIQDepth);
  localparam int CntW      = PtrW + 1;

  logic [DescWidth-1:0] q_mem [ROIQDepth];
  logic [PtrW-1:0]      wr_ptr, rd_ptr;
  logic [CntW-1:0]      q_count;
  logic [DescWidth-1:0] desc_in, held_desc;
  logic                 q_empty, q_full, enq, deq;
  logic                 path_start, roi_start;
  logic                 path_idle, roi_idle, path_tout, roi_tout;

  assign desc_in = {ROILevelIn, ROIBVIn, ROIBIDIn, ROIFromCCIn};
  assign q_empty = (q_count == '0);
  assign q_full  = (q_count == CntW'(ROIQDepth));

  assign ROIReqReady  = !q_full && !Reset;
  assign PathReqReady = path_idle && IVPathDone && !Error && !Reset;

  // Path handshake suppresses an ROI start in the same cycle, so the two
  // start pulses can never coincide.
  assign enq        = ROIReq && ROIReqReady;
  assign path_start = PathReq && PathReqReady;
  assign roi_start  = roi_idle && !q_empty && IVBOIDone && !Error && !path_start;
  assign deq        = roi_start;

  assign {IVROILevel, IVROIBV, IVROIBID, IVBOIFromCC} = held_desc;
  assign Busy = !path_idle || !roi_idle || !q_empty;

  iv_lane_ctrl #(.TimeoutCycles(TimeoutCycles)) u_path_lane (
    .clk         (Clock),
    .rst         (Reset),
    .start       (path_start),
    .done        (IVPathDone),
    .start_pulse (IVPathReady),
    .ack         (PathAck),
    .timeout     (path_tout),
    .idle        (path_idle),
    .state       (path_lane_state)
  );

  iv_lane_ctrl #(.TimeoutCycles(TimeoutCycles)) u_roi_lane (
    .clk         (Clock),
    .rst         (Reset),
    .start       (roi_start),
    .done        (IVBOIDone),
    .start_pulse (IVBOIReady),
    .ack         (ROIAck),
    .timeout     (roi_tout),
    .idle        (roi_idle),
    .state       (roi_lane_state)
  );

  // Descriptor storage; contents need no reset since occupancy is tracked.
  always_ff @(posedge Clock) begin
    if (enq) q_mem[wr_ptr] <= desc_in;
  end

  // Queue pointers and occupancy; power-of-2 depth makes pointers wrap.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_count <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   q_count <= q_count + 1'b1;
        2'b01:   q_count <= q_count - 1'b1;
        default: q_count <= q_count;
      endcase
    end
  end

  // Active descriptor loads on the edge entering START and stays until the
  // next ROI start, so it is stable from START through ACK.
  always_ff @(posedge Clock) begin
    if (Reset)          held_desc <= '0;
    else if (roi_start) held_desc <= q_mem[rd_ptr];
  end

  // Sticky watchdog error from either lane.
  always_ff @(posedge Clock) begin
    if (Reset)                       Error <= 1'b0;
    else if (path_tout || roi_tout)  Error <= 1'b1;
  end

endmodule

// File: tb/tb_iv_job_sequencer.sv
// Directed bench for iv_job_sequencer with a descriptor scoreboard. Inputs are
// driven 1 time unit after the rising edge; outputs are sampled there too.
module tb_iv_job_sequencer;
  import iv_job_sequencer_pkg::*;

  localparam int ORAML = 31;
  localparam int AES   = 64;
  localparam int TO    = 16;
  localparam int LW    = 5;
  localparam int BW    = 32;
  localparam int DW    = LW + AES + BW + 1;

  // ---------------- clock / reset / DUT ----------------
  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          PathReq = 1'b0, ROIReq = 1'b0, ROIFromCCIn = 1'b0;
  logic          IVPathDone = 1'b0, IVBOIDone = 1'b0;
  logic [LW-1:0] ROILevelIn = '0;
  logic [AES-1:0] ROIBVIn = '0;
  logic [BW-1:0] ROIBIDIn = '0;
  logic          PathReqReady, PathAck, ROIReqReady, ROIAck;
  logic          IVPathReady, IVBOIReady, IVBOIFromCC, Busy, Error;
  logic [LW-1:0] IVROILevel;
  logic [AES-1:0] IVROIBV;
  logic [BW-1:0] IVROIBID;
  lane_state_t   path_lane_state, roi_lane_state;

  iv_job_sequencer #(
    .ORAML(ORAML), .AESEntropy(AES), .ROIQDepth(2), .TimeoutCycles(TO)
  ) dut (
    .Clock(Clock), .Reset(Reset),
    .PathReq(PathReq), .PathReqReady(PathReqReady), .PathAck(PathAck),
    .ROIReq(ROIReq), .ROIReqReady(ROIReqReady),
    .ROILevelIn(ROILevelIn), .ROIBVIn(ROIBVIn), .ROIBIDIn(ROIBIDIn),
    .ROIFromCCIn(ROIFromCCIn), .ROIAck(ROIAck),
    .IVPathReady(IVPathReady), .IVBOIReady(IVBOIReady),
    .IVROILevel(IVROILevel), .IVROIBV(IVROIBV), .IVROIBID(IVROIBID),
    .IVBOIFromCC(IVBOIFromCC),
    .IVPathDone(IVPathDone), .IVBOIDone(IVBOIDone),
    .Busy(Busy), .Error(Error),
    .path_lane_state(path_lane_state), .roi_lane_state(roi_lane_state)
  );

  initial forever #5 Clock = ~Clock;

  initial begin
    #1000000;
    $display("FAIL sim_time_limit: observed timeout expected finish");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int             vectors = 0;
  int             miscompares = 0;
  logic [DW-1:0]  exp_q[$];
  logic [DW-1:0]  cur_desc = '0;
  logic           roi_active = 1'b0;
  logic [DW-1:0]  desc_out;

  assign desc_out = {IVROILevel, IVROIBV, IVROIBID, IVBOIFromCC};

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expected);
    vectors++;
    if (obs !== expected) begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, expected);
    end
  endtask

  function automatic logic [DW-1:0] mk(input int l, input logic [AES-1:0] bv,
                                       input logic [BW-1:0] bid, input logic cc);
    return {LW'(l), bv, bid, cc};
  endfunction

  // Per-cycle checks: start exclusivity, descriptor order and hold.
  task automatic monitor_step();
    if (!Reset) begin
      check("start_exclusive", 128'(IVPathReady & IVBOIReady), 0);
      if (IVBOIReady) begin
        if (exp_q.size() == 0) begin
          check("roi_unexpected_start", 1, 0);
        end else begin
          cur_desc = exp_q.pop_front();
          check("roi_desc", desc_out, cur_desc);
        end
        roi_active = 1'b1;
      end else if (roi_active) begin
        check("roi_hold", desc_out, cur_desc);
      end
      if (ROIAck) roi_active = 1'b0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge Clock);
      #1;
      monitor_step();
    end
  endtask

  function automatic logic sel(input int which);
    case (which)
      0:       return IVPathReady;
      1:       return IVBOIReady;
      2:       return PathAck;
      default: return ROIAck;
    endcase
  endfunction

  task automatic wait_out(input int which, input int budget, input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (sel(which)) begin
        found = 1'b1;
        break;
      end
    end
    check(tag, 128'(found), 1);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    PathReq = 1'b0;
    ROIReq = 1'b0;
    exp_q.delete();
    roi_active = 1'b0;
    tick(2);
    check("reset_outputs",
          {PathReqReady, PathAck, ROIReqReady, ROIAck, IVPathReady, IVBOIReady,
           desc_out, Busy, Error}, 0);
    Reset = 1'b0;
  endtask

  task automatic enq_roi(input logic [DW-1:0] d);
    {ROILevelIn, ROIBVIn, ROIBIDIn, ROIFromCCIn} = d;
    ROIReq = 1'b1;
    #1;
    check("roi_req_ready", 128'(ROIReqReady), 1);
    exp_q.push_back(d);
    tick();
    ROIReq = 1'b0;
  endtask

  // Called in the ROI START cycle: let Done go low, then complete the job.
  task automatic finish_roi();
    IVBOIDone = 1'b0;
    tick(3);
    IVBOIDone = 1'b1;
    wait_out(3, 6, "roi_ack");
  endtask

  // ---------------- tests ----------------
  initial begin
    int seen_roi, seen_ack;
    logic [DW-1:0] d;

    do_reset();

    // 1: path job, stale Done ignored in the guard cycles, ack after real Done
    IVPathDone = 1'b1;
    PathReq = 1'b1;
    #1;
    check("path_req_ready", 128'(PathReqReady), 1);
    tick();
    PathReq = 1'b0;
    check("iv_path_ready_pulse", 128'(IVPathReady), 1);
    tick();
    check("iv_path_ready_one_cycle", 128'(IVPathReady), 0);
    tick(2);
    IVPathDone = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("path_no_stale_ack", 128'(PathAck), 0);
    end
    IVPathDone = 1'b1;
    tick();
    check("path_ack", 128'(PathAck), 1);
    tick();
    check("path_ack_one_cycle", 128'(PathAck), 0);
    check("path_idle_busy", 128'(Busy), 0);

    // 2: two queued ROIs, served in order, each descriptor held for its job
    IVBOIDone = 1'b0;
    enq_roi(mk(3, 64'd5, 32'd9, 1'b0));
    enq_roi(mk(4, 64'd6, 32'd17, 1'b1));
    check("roi_full_not_ready", 128'(ROIReqReady), 0);
    check("roi_queued_busy", 128'(Busy), 1);
    tick(2);
    IVBOIDone = 1'b1;
    wait_out(1, 4, "roi_first_start");
    finish_roi();
    IVBOIDone = 1'b1;
    wait_out(1, 4, "roi_second_start");
    finish_roi();
    tick();
    check("roi_drained_busy", 128'(Busy), 0);

    // 3: same-cycle path request and ROI availability; path goes first
    IVBOIDone = 1'b0;
    enq_roi(mk(7, 64'hDEAD_BEEF_0123_4567, 32'h8000_0001, 1'b1));
    PathReq = 1'b1;
    IVPathDone = 1'b1;
    IVBOIDone = 1'b1;
    #1;
    check("collide_path_ready", 128'(PathReqReady), 1);
    tick();
    PathReq = 1'b0;
    check("collide_n1", {IVPathReady, IVBOIReady}, 2'b10);
    tick();
    check("collide_n2", {IVPathReady, IVBOIReady}, 2'b01);
    IVPathDone = 1'b0;
    IVBOIDone = 1'b0;
    tick(3);
    IVPathDone = 1'b1;
    IVBOIDone = 1'b1;
    tick();
    check("collide_both_ack", {PathAck, ROIAck}, 2'b11);
    tick();
    check("collide_idle_busy", 128'(Busy), 0);

    // 4: watchdog on the path lane
    do_reset();
    IVBOIDone = 1'b0;
    enq_roi(mk(1, 64'd2, 32'd3, 1'b0));
    IVPathDone = 1'b1;
    PathReq = 1'b1;
    tick();
    PathReq = 1'b0;
    IVPathDone = 1'b0;
    check("wd_start", 128'(IVPathReady), 1);
    for (int k = 1; k <= TO - 1; k++) begin
      tick();
      if (k == TO - 1) check("wd_error_before", 128'(Error), 0);
    end
    tick();
    check("wd_error_set", 128'(Error), 1);
    IVPathDone = 1'b1;
    IVBOIDone = 1'b1;
    #1;
    check("wd_path_not_ready", 128'(PathReqReady), 0);
    seen_roi = 0;
    seen_ack = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (IVBOIReady) seen_roi++;
      if (PathAck) seen_ack++;
    end
    check("wd_no_roi_start", 128'(seen_roi), 0);
    check("wd_no_path_ack", 128'(seen_ack), 0);
    check("wd_error_sticky", 128'(Error), 1);
    check("wd_queue_accepts", 128'(ROIReqReady), 1);
    check("wd_busy", 128'(Busy), 1);

    // 5: reset during ROI WAIT aborts silently
    do_reset();
    IVBOIDone = 1'b0;
    enq_roi(mk(9, 64'hFFFF_0000_FFFF_0000, 32'h1234_5678, 1'b1));
    IVBOIDone = 1'b1;
    wait_out(1, 4, "abort_roi_start");
    IVBOIDone = 1'b0;
    tick(3);
    Reset = 1'b1;
    exp_q.delete();
    roi_active = 1'b0;
    tick();
    check("abort_outputs",
          {PathReqReady, PathAck, ROIReqReady, ROIAck, IVPathReady, IVBOIReady,
           desc_out, Busy, Error}, 0);
    Reset = 1'b0;
    #1;
    check("abort_ready_after", 128'(ROIReqReady), 1);
    check("abort_busy_after", 128'(Busy), 0);
    IVBOIDone = 1'b1;
    enq_roi(mk(2, 64'd44, 32'd55, 1'b0));
    wait_out(1, 4, "abort_new_start");
    finish_roi();

    // 6: enqueue and dequeue on the same edge at depth-1, across pointer wrap
    do_reset();
    IVBOIDone = 1'b0;
    enq_roi(mk(5, 64'd100, 32'd200, 1'b1));
    for (int it = 0; it < 6; it++) begin
      d = {LW'($urandom_range(0, 31)), {$urandom, $urandom}, 32'($urandom),
           1'($urandom_range(0, 1))};
      {ROILevelIn, ROIBVIn, ROIBIDIn, ROIFromCCIn} = d;
      ROIReq = 1'b1;
      IVBOIDone = 1'b1;
      #1;
      check("wrap_ready", 128'(ROIReqReady), 1);
      exp_q.push_back(d);
      tick();
      ROIReq = 1'b0;
      IVBOIDone = 1'b0;
      check("wrap_start", 128'(IVBOIReady), 1);
      tick(3);
      IVBOIDone = 1'b1;
      tick();
      check("wrap_ack", 128'(ROIAck), 1);
      IVBOIDone = 1'b0;
      tick();
    end
    IVBOIDone = 1'b1;
    wait_out(1, 4, "wrap_last_start");
    finish_roi();
    tick();
    check("wrap_drained", 128'(exp_q.size()), 0);
    check("wrap_idle_busy", 128'(Busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
